// File: rtl/dribbler_speed_pkg.sv
// dribbler_speed_pkg
// Shared definitions for the dribbler speed controller: FSM state encoding,
// register map addresses and control/status bit positions.
// Optional feature macro used by the top level: DRIBBLER_SPEED_FILTER_EN.
package dribbler_speed_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  // Register map
  localparam logic [1:0] ADDR_SPEED = 2'd0;
  localparam logic [1:0] ADDR_GATE  = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_RSVD  = 2'd3;

  localparam int GATE_W = 24;

  // Control register: write-side bit positions
  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_OVF_CLR_BIT   = 1;
  localparam int CTRL_FRESH_CLR_BIT = 2;

  // Status register: read-side bit positions (fresh and ovf swap places
  // relative to the write side)
  localparam int STAT_ENABLE_BIT = 0;
  localparam int STAT_FRESH_BIT  = 1;
  localparam int STAT_OVF_BIT    = 2;

  // A zero gate would never terminate a window, so it behaves as one cycle.
  function automatic logic [GATE_W-1:0] effective_gate(input logic [GATE_W-1:0] gate);
    return (gate == '0) ? GATE_W'(1) : gate;
  endfunction

endpackage

// File: rtl/dribbler_edge_sync.sv
// dribbler_edge_sync
// Brings the asynchronous hall/encoder pulse into the clk domain through a
// SYNC_STAGES-deep flop chain and flags each rising edge of the synchronized
// signal as a single-cycle count event.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset, clears every flop
//   async_in - asynchronous input pulse
//   rise     - one-cycle strobe on each synchronized rising edge
module dribbler_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/dribbler_speed_ctrl.sv
// dribbler_speed_ctrl
// Counts dribbler hall pulses over a programmable gate window and publishes
// the count as a speed word. Small 4-register slave interface:
//   addr0 speed (RO), addr1 gate[23:0] (RW), addr2 control/status,
//   addr3 reads zero.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   address, write,
//   writedata         - register write interface
//   readdata          - registered read data, follows address one cycle later
//   hall_a            - asynchronous hall/encoder pulse
//   speed_out         - latest speed word, zero-extended
//   speed_valid       - one-cycle strobe when speed_out updates
// Optional feature: define DRIBBLER_SPEED_FILTER_EN to publish a first-order
// low-pass filtered speed instead of the raw pulse count.
module dribbler_speed_ctrl
  import dribbler_speed_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int GATE_DEFAULT = 50000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        hall_a,
  output logic [31:0] speed_out,
  output logic        speed_valid
);

  state_t              state_q, state_d;
  logic                enable_q;
  logic [GATE_W-1:0]   gate_q;
  logic [GATE_W-1:0]   shadow_q;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [CNT_W-1:0]    pulse_cnt_q;
  logic [CNT_W-1:0]    speed_q;
  logic [CNT_W-1:0]    publish_value;
  logic                speed_valid_q;
  logic                ovf_q;
  logic                fresh_q;
  logic [31:0]         readdata_q;

  logic                count_event;
  logic                window_done;
  logic                measuring;
  logic                ovf_set;
  logic                ctrl_write;
  logic                unused_writedata;

  assign unused_writedata = ^writedata[31:GATE_W];

  dribbler_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(hall_a),
    .rise    (count_event)
  );

  assign window_done = (gate_cnt_q >= (shadow_q - GATE_W'(1)));
  assign measuring   = (state_q == ST_MEASURE) && enable_q;
  assign ovf_set     = measuring && count_event && (&pulse_cnt_q);
  assign ctrl_write  = write && (address == ADDR_CTRL);

`ifdef DRIBBLER_SPEED_FILTER_EN
  // speed += (count - speed) / 4, evaluated signed two bits wider than the
  // counter so the difference cannot wrap, then clamped to the counter range.
  localparam int FW = CNT_W + 2;
  localparam logic signed [FW-1:0] FILT_MAX = $signed({2'b00, {CNT_W{1'b1}}});

  logic signed [FW-1:0] filt_diff;
  logic signed [FW-1:0] filt_sum;

  always_comb begin
    filt_diff = $signed({2'b00, pulse_cnt_q}) - $signed({2'b00, speed_q});
    filt_sum  = $signed({2'b00, speed_q}) + (filt_diff >>> 2);
    if (filt_sum[FW-1]) begin
      publish_value = '0;
    end else if (filt_sum > FILT_MAX) begin
      publish_value = '1;
    end else begin
      publish_value = filt_sum[CNT_W-1:0];
    end
  end
`else
  assign publish_value = pulse_cnt_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable abandons the window from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_q) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable_q)        state_d = ST_IDLE;
        else if (window_done) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        state_d = enable_q ? ST_MEASURE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registers, sticky flags and measurement datapath.
  // The PUBLISH cycle is the first cycle of the following window, so the gate
  // counter restarts at 1 there and an event in that cycle seeds the new
  // pulse count; back-to-back windows therefore repeat every gate cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q      <= 1'b0;
      gate_q        <= GATE_W'(GATE_DEFAULT);
      shadow_q      <= '0;
      gate_cnt_q    <= '0;
      pulse_cnt_q   <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      ovf_q         <= 1'b0;
      fresh_q       <= 1'b0;
    end else begin
      speed_valid_q <= 1'b0;

      if (write && (address == ADDR_GATE)) begin
        gate_q <= writedata[GATE_W-1:0];
      end
      if (ctrl_write) begin
        enable_q <= writedata[CTRL_ENABLE_BIT];
      end

      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ctrl_write && writedata[CTRL_OVF_CLR_BIT]) begin
        ovf_q <= 1'b0;
      end

      if (state_q == ST_PUBLISH) begin
        fresh_q <= 1'b1;
      end else if (ctrl_write && writedata[CTRL_FRESH_CLR_BIT]) begin
        fresh_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          gate_cnt_q  <= '0;
          pulse_cnt_q <= '0;
          if (enable_q) shadow_q <= effective_gate(gate_q);
        end
        ST_MEASURE: begin
          if (!enable_q) begin
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
          end else begin
            gate_cnt_q <= gate_cnt_q + GATE_W'(1);
            if (count_event && !(&pulse_cnt_q)) begin
              pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PUBLISH: begin
          speed_q       <= publish_value;
          speed_valid_q <= 1'b1;
          gate_cnt_q    <= GATE_W'(1);
          pulse_cnt_q   <= CNT_W'(count_event);
          shadow_q      <= effective_gate(gate_q);
        end
        default: begin
          gate_cnt_q  <= '0;
          pulse_cnt_q <= '0;
        end
      endcase
    end
  end

  // Read mux, registered every cycle without any read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      case (address)
        ADDR_SPEED: readdata_q <= 32'(speed_q);
        ADDR_GATE:  readdata_q <= 32'(gate_q);
        ADDR_CTRL:  readdata_q <= {29'b0, ovf_q, fresh_q, enable_q};
        default:    readdata_q <= '0;
      endcase
    end
  end

  assign readdata    = readdata_q;
  assign speed_out   = 32'(speed_q);
  assign speed_valid = speed_valid_q;

endmodule

// File: doc/dribbler_speed_ctrl.md
DRIBBLER_SPEED_CTRL -- requirements
Module: dribbler_speed_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, pulse-counter width.
REQ-002 SHALL have parameter GATE_DEFAULT, default 50000, gate length in clk cycles after reset.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for hall_a.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 address  input  2  register select.
REQ-008 write  input  1  register write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 hall_a  input  1  asynchronous dribbler hall/encoder pulse.
REQ-012 speed_out  output  32  latest speed word, zero-extended, feeds PIO in_port.
REQ-013 speed_valid  output  1  one-cycle pulse when speed_out updates.

Function
REQ-014 hall_a SHALL pass SYNC_STAGES flops; a rising edge on the synchronized signal SHALL be one count event.
REQ-015 Registers: addr0 speed_out (RO); addr1 gate[23:0] (RW); addr2 control/status; addr3 reads zero, writes ignored.
REQ-016 addr2 write: bit0 enable; bit1 W1C overflow; bit2 W1C fresh. addr2 read: {29'b0, ovf, fresh, enable}.
REQ-017 readdata SHALL reflect address one cycle after it is presented, every cycle, no read strobe, no read side effects.
REQ-018 Gate value 0 SHALL be treated as 1.
REQ-019 FSM states IDLE, MEASURE, PUBLISH.
REQ-020 IDLE: counters held zero; enable=1 -> MEASURE next cycle, shadow gate loaded from gate register.
REQ-021 MEASURE: gate counter increments each cycle; count events increment pulse counter, saturating at 2^CNT_W-1 and setting sticky ovf; gate counter == shadow-1 -> PUBLISH.
REQ-022 Event in the terminal MEASURE cycle SHALL belong to the current window.
REQ-023 PUBLISH (one cycle): speed_out updated, speed_valid=1, fresh set, counters cleared, shadow gate reloaded; next state MEASURE if enable else IDLE.
REQ-024 Event during PUBLISH SHALL be the first count of the next window.
REQ-025 Gate writes mid-window SHALL take effect only at the next window start.
REQ-026 enable cleared during MEASURE -> IDLE next cycle, window discarded, speed_out retained, no speed_valid.
REQ-027 Simultaneous W1C and set of fresh/ovf: set wins.

Reset
REQ-028 On reset: FSM IDLE, enable 0, gate=GATE_DEFAULT, counters 0, speed_out 0, speed_valid 0, readdata 0, ovf 0, fresh 0, synchronizer flops 0.
REQ-029 Reset mid-window SHALL discard the window without speed_valid.

Configuration
REQ-030 Macro DRIBBLER_SPEED_FILTER_EN defined: PUBLISH SHALL load speed_out <= speed_out + ((count - speed_out) >>> 2), signed arithmetic at CNT_W+2 bits, result clamped to 0..2^CNT_W-1.
REQ-031 Macro undefined: PUBLISH SHALL load raw pulse count; no filter logic present.

Structure
REQ-032 Package dribbler_speed_pkg SHALL hold FSM state enum, register address constants, control/status bit positions.
REQ-033 Sub-module dribbler_edge_sync SHALL implement synchronizer plus rising-edge detect.

Verification
REQ-034 gate=100, enable, 10 hall pulses per window -> speed_valid every 100 cycles, speed_out=10 (unfiltered build).
REQ-035 CNT_W=4, 20 pulses in window -> speed_out=15, ovf=1; write addr2=0x3 -> ovf=0, enable stays 1.
REQ-036 gate 100 -> write 50 mid-window -> current window 100 cycles, next windows 50 cycles.
REQ-037 Pulse edges on terminal and PUBLISH cycles -> counted in current and next window respectively.
REQ-038 Clear enable mid-window -> no speed_valid, IDLE, speed_out unchanged; reset mid-window -> all outputs 0.
REQ-039 Filter build, speed_out=0, constant 40 per window -> speed_out 10, 17, 22, 26.
